// File: rtl/spi_sclk_gen.sv
// SPI serial-clock generator: bounded bursts of nbits SCLK cycles in any CPOL/CPHA mode,
// with start/busy/done handshake, synchronous abort and registered per-edge strobes.
module spi_sclk_gen #(
    parameter int DIV_W = 8,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [DIV_W-1:0] clk_div,
    input  logic             cpol,
    input  logic             cpha,
    input  logic [CNT_W-1:0] nbits,
    output logic             spi_clk,
    output logic             spi_rise,
    output logic             spi_fall,
    output logic             sample,
    output logic             shift,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, RUN, TAIL} state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W:0]   edge_q, edge_d;
    logic [CNT_W-1:0] nbits_q, nbits_d;
    logic             cpol_q, cpol_d;
    logic             cpha_q, cpha_d;
    logic             sclk_q, sclk_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             sample_q, sample_d;
    logic             shift_q, shift_d;
    logic             done_q, done_d;

    logic             half_end;
    logic             leading;
    logic [CNT_W:0]   edge_inc;
    logic [CNT_W:0]   last_edge;
    logic [DIV_W-1:0] hcnt_inc;

    assign half_end  = (hcnt_q == div_q);
    assign edge_inc  = edge_q + {{CNT_W{1'b0}}, 1'b1};
    assign last_edge = {nbits_q, 1'b0};
    assign hcnt_inc  = hcnt_q + {{(DIV_W-1){1'b0}}, 1'b1};
    // Edges are numbered from 1; odd-numbered edges move away from the idle level.
    assign leading   = ~edge_q[0];

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        hcnt_d   = hcnt_q;
        edge_d   = edge_q;
        nbits_d  = nbits_q;
        cpol_d   = cpol_q;
        cpha_d   = cpha_q;
        sclk_d   = sclk_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        sample_d = 1'b0;
        shift_d  = 1'b0;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                sclk_d = cpol;
                // The done cycle is still IDLE but must not accept a new request.
                if (start && !stop && (nbits != '0) && !done_q) begin
                    div_d   = clk_div;
                    cpol_d  = cpol;
                    cpha_d  = cpha;
                    nbits_d = nbits;
                    hcnt_d  = '0;
                    edge_d  = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    sclk_d  = cpol_q;
                    state_d = IDLE;
                end else if (half_end) begin
                    hcnt_d   = '0;
                    edge_d   = edge_inc;
                    sclk_d   = ~sclk_q;
                    rise_d   = ~sclk_q;
                    fall_d   = sclk_q;
                    sample_d = leading ^ cpha_q;
                    shift_d  = ~(leading ^ cpha_q);
                    if (edge_inc == last_edge) begin
                        state_d = TAIL;
                    end
                end else begin
                    hcnt_d = hcnt_inc;
                end
            end
            TAIL: begin
                if (stop) begin
                    sclk_d  = cpol_q;
                    state_d = IDLE;
                end else if (half_end) begin
                    hcnt_d  = '0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    hcnt_d = hcnt_inc;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            div_q    <= '0;
            hcnt_q   <= '0;
            edge_q   <= '0;
            nbits_q  <= '0;
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
            sclk_q   <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            sample_q <= 1'b0;
            shift_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            hcnt_q   <= hcnt_d;
            edge_q   <= edge_d;
            nbits_q  <= nbits_d;
            cpol_q   <= cpol_d;
            cpha_q   <= cpha_d;
            sclk_q   <= sclk_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            sample_q <= sample_d;
            shift_q  <= shift_d;
            done_q   <= done_d;
        end
    end

    assign spi_clk  = sclk_q;
    assign spi_rise = rise_q;
    assign spi_fall = fall_q;
    assign sample   = sample_q;
    assign shift    = shift_q;
    assign busy     = (state_q != IDLE);
    assign done     = done_q;

endmodule

// File: tb/tb_spi_sclk_gen.sv
// Bench for spi_sclk_gen: every cycle of each burst is compared against an arithmetic
// model derived from the edge schedule T+1+k*D, k=1..2N, done at T+1+(2N+1)*D.
module tb_spi_sclk_gen;

    localparam int DIV_W = 8;
    localparam int CNT_W = 6;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             stop;
    logic [DIV_W-1:0] clk_div;
    logic             cpol;
    logic             cpha;
    logic [CNT_W-1:0] nbits;
    logic             spi_clk, spi_rise, spi_fall, sample, shift, busy, done;

    int vectors = 0;
    int miscompares = 0;

    spi_sclk_gen #(.DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .clk_div(clk_div),
        .cpol(cpol), .cpha(cpha), .nbits(nbits), .spi_clk(spi_clk),
        .spi_rise(spi_rise), .spi_fall(spi_fall), .sample(sample), .shift(shift),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected {spi_clk,rise,fall,sample,shift,busy,done} at offset t cycles after the accept cycle.
    function automatic logic [6:0] model(input int t, input int cp, input int ch, input int dv, input int nb);
        int D, last, k, ke;
        bit lvl, strb, lead;
        D    = dv + 1;
        last = (2 * nb + 1) * D + 1;
        k    = (t - 1) / D;
        ke   = (k > 2 * nb) ? 2 * nb : k;
        lvl  = ((cp + ke) % 2) == 1;
        strb = ((t - 1) % D == 0) && (k >= 1) && (k <= 2 * nb);
        lead = (k % 2) == 1;
        return {lvl, strb && lvl, strb && !lvl, strb && (ch != 0 ? !lead : lead),
                strb && (ch != 0 ? lead : !lead), t < last, t == last};
    endfunction

    // Starts a burst in the current cycle and checks every following cycle; optional abort at
    // offset stop_at, mid-burst input scrambling, start while busy, and start in the done cycle.
    task automatic run_burst(input string name, input int cp, input int ch, input int dv, input int nb,
                             input int stop_at, input bit scramble, input bit poke,
                             input bit start_in_done, output int done_off);
        int last, end_t;
        logic [6:0] got, exp;
        done_off = -1;
        last  = (2 * nb + 1) * (dv + 1) + 1;
        end_t = (stop_at > 0) ? stop_at + 1 : last;
        cpol = cp[0]; cpha = ch[0]; clk_div = dv[DIV_W-1:0]; nbits = nb[CNT_W-1:0];
        start = 1'b1; stop = 1'b0;
        for (int t = 1; t <= end_t; t++) begin
            tick();
            start = 1'b0;
            got = {spi_clk, spi_rise, spi_fall, sample, shift, busy, done};
            if (stop_at > 0 && t == stop_at + 1) exp = {cp[0], 6'b0};
            else exp = model(t, cp, ch, dv, nb);
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL %s t=%0d got=%b exp=%b", name, t, got, exp);
            end
            if (done === 1'b1 && done_off < 0) done_off = t;
            if (scramble && t == 2 && t < end_t) begin
                clk_div = DIV_W'($urandom); cpol = 1'($urandom);
                cpha = 1'($urandom); nbits = CNT_W'($urandom);
            end
            if (poke && t == 3 && t < end_t) start = 1'b1;
            stop = (t == stop_at);
            if (start_in_done && t == last && stop_at == 0) begin
                cpol = cp[0]; cpha = ch[0]; clk_div = dv[DIV_W-1:0]; nbits = nb[CNT_W-1:0];
                start = 1'b1;
            end
        end
        stop = 1'b0;
        tick();
        got = {spi_clk, spi_rise, spi_fall, sample, shift, busy, done};
        vectors++;
        if (got[1:0] !== 2'b00) begin
            miscompares++;
            $display("FAIL %s_after busy/done=%b exp=00", name, got[1:0]);
        end
    endtask

    task automatic test_reset();
        int d;
        rst = 1'b1; start = 1'b0; stop = 1'b0; cpol = 1'b1; cpha = 1'b0; clk_div = '0; nbits = '0;
        tick(); tick();
        vectors++;
        if ({spi_clk, spi_rise, spi_fall, sample, shift, busy, done} !== 7'b0) begin
            miscompares++;
            $display("FAIL reset_state got=%b exp=0000000", {spi_clk, spi_rise, spi_fall, sample, shift, busy, done});
        end
        rst = 1'b0; cpol = 1'b0;
        tick(); tick();
        // Mid-burst reset while spi_clk is high (mode 0, div=1: high at offset 3).
        clk_div = 8'd1; nbits = 6'd2; start = 1'b1;
        tick(); start = 1'b0;
        tick(); tick();
        vectors++;
        if ({spi_clk, spi_rise, busy} !== 3'b111) begin
            miscompares++;
            $display("FAIL pre_reset clk/rise/busy=%b exp=111", {spi_clk, spi_rise, busy});
        end
        rst = 1'b1; cpol = 1'b1;
        tick();
        vectors++;
        if ({spi_clk, spi_rise, spi_fall, sample, shift, busy, done} !== 7'b0) begin
            miscompares++;
            $display("FAIL midrun_reset got=%b exp=0000000", {spi_clk, spi_rise, spi_fall, sample, shift, busy, done});
        end
        rst = 1'b0;
        tick();
        vectors++;
        if ({spi_clk, busy, done} !== 3'b100) begin
            miscompares++;
            $display("FAIL reset_release clk/busy/done=%b exp=100", {spi_clk, busy, done});
        end
        tick();
        run_burst("post_reset", 1, 0, 1, 1, 0, 0, 0, 0, d);
    endtask

    task automatic test_modes();
        int d;
        run_burst("mode0", 0, 0, 1, 2, 0, 0, 0, 0, d);
        vectors++;
        if (d !== 11) begin miscompares++; $display("FAIL mode0_done_offset got=%0d exp=11", d); end
        run_burst("mode1", 0, 1, 1, 2, 0, 0, 0, 0, d);
        run_burst("mode2", 1, 0, 2, 3, 0, 0, 0, 0, d);
        run_burst("mode3", 1, 1, 0, 1, 0, 0, 0, 0, d);
        vectors++;
        if (d !== 4) begin miscompares++; $display("FAIL mode3_done_offset got=%0d exp=4", d); end
    endtask

    task automatic test_abort();
        int d;
        run_burst("abort", 0, 0, 3, 4, 6, 0, 0, 0, d);
        vectors++;
        if (d !== -1) begin miscompares++; $display("FAIL abort_no_done got=%0d exp=-1", d); end
        run_burst("after_abort", 0, 0, 3, 1, 0, 0, 0, 0, d);
        run_burst("abort_tail", 1, 1, 2, 2, 15, 0, 0, 0, d);
    endtask

    task automatic test_ignored();
        int d;
        cpol = 1'b1; cpha = 1'b0; clk_div = 8'd1; nbits = '0; start = 1'b1; stop = 1'b0;
        tick(); start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if ({spi_clk, busy, done} !== 3'b100) begin
                miscompares++;
                $display("FAIL nbits0_ignored clk/busy/done=%b exp=100", {spi_clk, busy, done});
            end
        end
        cpol = 1'b0; nbits = 6'd3; start = 1'b1; stop = 1'b1;
        tick(); start = 1'b0; stop = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if ({spi_clk, busy, done} !== 3'b000) begin
                miscompares++;
                $display("FAIL startstop_ignored clk/busy/done=%b exp=000", {spi_clk, busy, done});
            end
        end
        run_burst("div_change", 0, 0, 1, 3, 0, 1, 0, 0, d);
        run_burst("start_busy", 1, 0, 2, 2, 0, 0, 1, 0, d);
    endtask

    task automatic test_back_to_back();
        int d;
        run_burst("b2b_first", 0, 1, 1, 2, 0, 0, 0, 1, d);
        run_burst("b2b_second", 0, 1, 1, 2, 0, 0, 0, 0, d);
    endtask

    task automatic test_boundary();
        int d;
        run_burst("div0", 0, 1, 0, 5, 0, 0, 0, 0, d);
        run_burst("div0_nmax", 1, 0, 0, 63, 0, 0, 0, 0, d);
        run_burst("divmax", 0, 0, 255, 1, 0, 0, 0, 0, d);
        run_burst("divmax_nmax", 1, 1, 255, 63, 0, 0, 0, 0, d);
    endtask

    task automatic test_random();
        int d, cp, ch, dv, nb, sa;
        for (int i = 0; i < 30; i++) begin
            cp = $urandom_range(0, 1); ch = $urandom_range(0, 1);
            dv = $urandom_range(0, 6); nb = $urandom_range(1, 12);
            sa = ($urandom_range(0, 3) == 0) ? $urandom_range(1, (2 * nb + 1) * (dv + 1)) : 0;
            run_burst("random", cp, ch, dv, nb, sa, 1'($urandom), 1'($urandom), 0, d);
        end
    endtask

    initial begin
        test_reset();
        test_modes();
        test_abort();
        test_ignored();
        test_back_to_back();
        test_boundary();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
